// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage register: occupancy encoding
// and the zero-payload constant used on reset and flush.
package pipe_pkg;

    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] FULL1 = 2'd1;
    localparam logic [1:0] FULL2 = 2'd2;

    // Replicated to any payload width as {DATA_W{PIPE_ZERO_BIT}}
    localparam logic PIPE_ZERO_BIT = 1'b0;

endpackage

// File: rtl/pipe_skid_entry.sv
// Single valid + payload register with load and clear; used for both the
// main entry and the skid entry of pipe_stage_reg.
module pipe_skid_entry
    import pipe_pkg::*;
#(
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              clear,
    input  logic              zero,
    input  logic [DATA_W-1:0] d,
    output logic              vld,
    output logic [DATA_W-1:0] q
);

    logic              vld_p0;
    logic [DATA_W-1:0] data_p0;

    // Clear wins over load; zero only touches the data bits
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p0  <= 1'b0;
            data_p0 <= {DATA_W{PIPE_ZERO_BIT}};
        end else begin
            if (clear)
                vld_p0 <= 1'b0;
            else if (load)
                vld_p0 <= 1'b1;

            if (zero)
                data_p0 <= {DATA_W{PIPE_ZERO_BIT}};
            else if (load && !clear)
                data_p0 <= d;
        end
    end

    assign vld = vld_p0;
    assign q   = data_p0;

endmodule

// File: rtl/pipe_stage_reg.sv
// Reusable pipeline boundary register with valid/ready handshake, hazard
// stall, flush-to-bubble and an optional two-entry skid buffer.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W     = 64,
    parameter bit SKID_EN    = 1'b1,
    parameter bit FLUSH_ZERO = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    input  logic              stall,
    input  logic              flush,
    output logic [1:0]        occ
);

    logic              in_fire;
    logic              out_fire;
    logic              main_vld;
    logic              skid_vld;
    logic [DATA_W-1:0] main_q;
    logic [DATA_W-1:0] skid_q;
    logic [DATA_W-1:0] main_d;
    logic              main_load;
    logic              main_clr;
    logic              skid_load;
    logic              skid_clr;
    logic              zero_on_flush;
    logic [1:0]        state;
    logic [1:0]        state_d;

    // Occupancy is decoded from the entry valids; the skid is only ever
    // filled while the main entry is full
    assign state = skid_vld ? FULL2 : (main_vld ? FULL1 : EMPTY);

    assign in_fire       = in_valid & in_ready;
    assign out_fire      = main_vld & out_ready & ~stall;
    assign zero_on_flush = flush & FLUSH_ZERO;

    assign out_valid = main_vld;
    assign out_data  = main_q;
    assign occ       = state;

    always_comb begin
        main_load = 1'b0;
        main_clr  = 1'b0;
        main_d    = in_data;
        skid_load = 1'b0;
        skid_clr  = 1'b0;
        state_d   = state;
        if (flush) begin
            main_clr = 1'b1;
            skid_clr = 1'b1;
            state_d  = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_fire) begin
                        main_load = 1'b1;
                        state_d   = FULL1;
                    end
                end
                FULL1: begin
                    if (in_fire && !out_fire && SKID_EN) begin
                        skid_load = 1'b1;
                        state_d   = FULL2;
                    end else if (in_fire) begin
                        main_load = 1'b1;
                    end else if (out_fire) begin
                        main_clr = 1'b1;
                        state_d  = EMPTY;
                    end
                end
                FULL2: begin
                    if (out_fire) begin
                        main_load = 1'b1;
                        main_d    = skid_q;
                        skid_clr  = 1'b1;
                        state_d   = FULL1;
                    end
                end
                default: ;
            endcase
        end
    end

    pipe_skid_entry #(.DATA_W(DATA_W)) u_main (
        .clk   (clk),
        .rst   (rst),
        .load  (main_load),
        .clear (main_clr),
        .zero  (zero_on_flush),
        .d     (main_d),
        .vld   (main_vld),
        .q     (main_q)
    );

    generate
        if (SKID_EN) begin : g_skid
            logic rdy_p0;

            pipe_skid_entry #(.DATA_W(DATA_W)) u_skid (
                .clk   (clk),
                .rst   (rst),
                .load  (skid_load),
                .clear (skid_clr),
                .zero  (zero_on_flush),
                .d     (in_data),
                .vld   (skid_vld),
                .q     (skid_q)
            );

            // Registered ready: low only when the next state has both entries full
            always_ff @(posedge clk) begin
                if (rst)
                    rdy_p0 <= 1'b0;
                else
                    rdy_p0 <= (state_d != FULL2);
            end

            assign in_ready = rdy_p0;
        end else begin : g_noskid
            assign skid_vld = 1'b0;
            assign skid_q   = {DATA_W{PIPE_ZERO_BIT}};
            assign in_ready = ~rst & (~main_vld | (out_ready & ~stall));
        end
    endgenerate

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: vector table on the skid variant, handshake and
// random ordering checks on the single-entry variant, both scoreboarded.
module tb_pipe_stage_reg;

    localparam int DW = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid, in_ready, out_valid, out_ready, stall, flush;
    logic [DW-1:0] in_data, out_data;
    logic [1:0]    occ;
    logic          in_valid_z, in_ready_z, out_valid_z, out_ready_z, stall_z, flush_z;
    logic [DW-1:0] in_data_z, out_data_z;
    logic [1:0]    occ_z;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] sb[$];
    logic [DW-1:0] sb_z[$];

    typedef struct {
        logic          iv;
        logic [DW-1:0] d;
        logic          ordy;
        logic          st;
        logic          fl;
        logic          e_ov;
        logic [DW-1:0] e_od;
        logic          chk_od;
        logic [1:0]    e_occ;
        logic          e_ir;
    } vec_t;

    localparam int NVEC = 27;
    vec_t vecs[NVEC];

    pipe_stage_reg #(.DATA_W(DW), .SKID_EN(1'b1), .FLUSH_ZERO(1'b1)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .stall     (stall),
        .flush     (flush),
        .occ       (occ)
    );

    pipe_stage_reg #(.DATA_W(DW), .SKID_EN(1'b0), .FLUSH_ZERO(1'b1)) dut_z (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid_z),
        .in_ready  (in_ready_z),
        .in_data   (in_data_z),
        .out_valid (out_valid_z),
        .out_ready (out_ready_z),
        .out_data  (out_data_z),
        .stall     (stall_z),
        .flush     (flush_z),
        .occ       (occ_z)
    );

    always #10 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input int iv, input longint d, input int ordy, input int st,
                                input int fl, input int e_ov, input longint e_od,
                                input int chk_od, input int e_occ, input int e_ir);
        vec_t v;
        v.iv     = 1'(iv);
        v.d      = 64'(d);
        v.ordy   = 1'(ordy);
        v.st     = 1'(st);
        v.fl     = 1'(fl);
        v.e_ov   = 1'(e_ov);
        v.e_od   = 64'(e_od);
        v.chk_od = 1'(chk_od);
        v.e_occ  = 2'(e_occ);
        v.e_ir   = 1'(e_ir);
        return v;
    endfunction

    // Scoreboards: decide handshakes mid-cycle, when inputs and outputs are stable
    always @(negedge clk) begin : mon_skid
        logic [DW-1:0] e;
        if (rst || flush) begin
            sb.delete();
        end else begin
            if (out_valid && out_ready && !stall) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_skid: got %0h, expected no output", out_data);
                end else begin
                    e = sb.pop_front();
                    chk("sb_skid", out_data, e);
                end
            end
            if (in_valid && in_ready)
                sb.push_back(in_data);
        end
    end

    always @(negedge clk) begin : mon_noskid
        logic [DW-1:0] e;
        if (rst || flush_z) begin
            sb_z.delete();
        end else begin
            if (out_valid_z && out_ready_z && !stall_z) begin
                if (sb_z.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_noskid: got %0h, expected no output", out_data_z);
                end else begin
                    e = sb_z.pop_front();
                    chk("sb_noskid", out_data_z, e);
                end
            end
            if (in_valid_z && in_ready_z)
                sb_z.push_back(in_data_z);
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "timeout");
    end

    initial begin
        // iv, data, out_ready, stall, flush | out_valid, out_data, check data, occ, in_ready
        vecs[0]  = mk(1, 1,  1, 0, 0,  1, 1,  1, 1, 1);
        vecs[1]  = mk(1, 2,  1, 0, 0,  1, 2,  1, 1, 1);
        vecs[2]  = mk(1, 3,  1, 0, 0,  1, 3,  1, 1, 1);
        vecs[3]  = mk(1, 4,  1, 0, 0,  1, 4,  1, 1, 1);
        vecs[4]  = mk(0, 0,  1, 0, 0,  0, 0,  0, 0, 1);
        vecs[5]  = mk(1, 5,  0, 0, 0,  1, 5,  1, 1, 1);
        vecs[6]  = mk(1, 6,  0, 0, 0,  1, 5,  1, 2, 0);
        vecs[7]  = mk(1, 99, 0, 0, 0,  1, 5,  1, 2, 0);
        vecs[8]  = mk(0, 0,  1, 0, 0,  1, 6,  1, 1, 1);
        vecs[9]  = mk(0, 0,  1, 0, 0,  0, 0,  0, 0, 1);
        vecs[10] = mk(1, 7,  1, 0, 0,  1, 7,  1, 1, 1);
        vecs[11] = mk(0, 0,  1, 1, 0,  1, 7,  1, 1, 1);
        vecs[12] = mk(0, 0,  1, 1, 0,  1, 7,  1, 1, 1);
        vecs[13] = mk(0, 0,  1, 1, 0,  1, 7,  1, 1, 1);
        vecs[14] = mk(0, 0,  1, 1, 0,  1, 7,  1, 1, 1);
        vecs[15] = mk(0, 0,  1, 0, 0,  0, 0,  0, 0, 1);
        vecs[16] = mk(1, 8,  0, 0, 0,  1, 8,  1, 1, 1);
        vecs[17] = mk(1, 9,  0, 0, 0,  1, 8,  1, 2, 0);
        vecs[18] = mk(1, 10, 0, 0, 1,  0, 0,  1, 0, 1);
        vecs[19] = mk(0, 0,  1, 0, 0,  0, 0,  1, 0, 1);
        vecs[20] = mk(1, 11, 0, 0, 0,  1, 11, 1, 1, 1);
        vecs[21] = mk(1, 12, 0, 1, 1,  0, 0,  1, 0, 1);
        vecs[22] = mk(0, 0,  1, 0, 0,  0, 0,  1, 0, 1);
        vecs[23] = mk(1, 13, 1, 0, 0,  1, 13, 1, 1, 1);
        vecs[24] = mk(1, 14, 1, 1, 0,  1, 13, 1, 2, 0);
        vecs[25] = mk(0, 0,  1, 0, 0,  1, 14, 1, 1, 1);
        vecs[26] = mk(0, 0,  1, 0, 0,  0, 0,  0, 0, 1);

        rst         = 1'b1;
        in_valid    = 1'b1;
        in_data     = 64'hDEAD;
        out_ready   = 1'b0;
        stall       = 1'b0;
        flush       = 1'b0;
        in_valid_z  = 1'b1;
        in_data_z   = 64'hDEAD;
        out_ready_z = 1'b0;
        stall_z     = 1'b0;
        flush_z     = 1'b0;

        repeat (3) begin
            @(posedge clk); #1;
            chk("rst_out_valid", 64'(out_valid), 64'(0));
            chk("rst_out_data",  out_data, 64'(0));
            chk("rst_occ",       64'(occ), 64'(0));
            chk("rst_in_ready",  64'(in_ready), 64'(0));
            chk("rst_in_ready_z", 64'(in_ready_z), 64'(0));
            chk("rst_out_valid_z", 64'(out_valid_z), 64'(0));
        end
        rst        = 1'b0;
        in_valid   = 1'b0;
        in_valid_z = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_in_ready",   64'(in_ready), 64'(1));
        chk("post_rst_in_ready_z", 64'(in_ready_z), 64'(1));
        chk("post_rst_occ",        64'(occ), 64'(0));

        for (int i = 0; i < NVEC; i++) begin
            in_valid  = vecs[i].iv;
            in_data   = vecs[i].d;
            out_ready = vecs[i].ordy;
            stall     = vecs[i].st;
            flush     = vecs[i].fl;
            @(posedge clk); #1;
            chk($sformatf("vec%0d_out_valid", i), 64'(out_valid), 64'(vecs[i].e_ov));
            chk($sformatf("vec%0d_occ", i),       64'(occ),       64'(vecs[i].e_occ));
            chk($sformatf("vec%0d_in_ready", i),  64'(in_ready),  64'(vecs[i].e_ir));
            if (vecs[i].chk_od)
                chk($sformatf("vec%0d_out_data", i), out_data, vecs[i].e_od);
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        stall     = 1'b0;
        flush     = 1'b0;
        chk("sb_skid_drained", 64'(sb.size()), 64'(0));

        // Single-entry variant: load one payload, then probe the combinational ready
        in_valid_z  = 1'b1;
        in_data_z   = 64'h100;
        out_ready_z = 1'b0;
        @(posedge clk); #1;
        in_valid_z = 1'b0;
        chk("z_load_out_valid", 64'(out_valid_z), 64'(1));
        chk("z_load_out_data",  out_data_z, 64'h100);
        chk("z_load_occ",       64'(occ_z), 64'(1));
        for (int k = 0; k < 4; k++) begin
            out_ready_z = k[0];
            stall_z     = k[1];
            #1;
            chk($sformatf("z_ready_or%0d_st%0d", k & 1, k >> 1), 64'(in_ready_z),
                64'(k[0] & ~k[1]));
        end
        out_ready_z = 1'b0;
        stall_z     = 1'b0;

        for (int c = 0; c < 100; c++) begin
            in_valid_z  = 1'($urandom_range(0, 1));
            in_data_z   = {$urandom(), $urandom()};
            out_ready_z = 1'($urandom_range(0, 1));
            stall_z     = ($urandom_range(0, 3) == 0);
            flush_z     = ($urandom_range(0, 15) == 0);
            @(posedge clk); #1;
            chk("z_occ_max", 64'(occ_z <= 2'd1), 64'(1));
        end
        in_valid_z  = 1'b0;
        flush_z     = 1'b0;
        stall_z     = 1'b0;
        out_ready_z = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("sb_noskid_drained", 64'(sb_z.size()), 64'(0));
        chk("z_drained_out_valid", 64'(out_valid_z), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
